// File: rtl/adc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_ctrl_pkg
// Description : Shared types and constants for the ADC extended-control
//               power-up configuration master: frame layout constants, the
//               register init table (send order), FSM state encoding and a
//               helper that assembles one 32-bit serial frame.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_ctrl_pkg;

  localparam logic [3:0] FRAME_HDR  = 4'b0001;
  localparam logic [7:0] FRAME_PAD  = 8'hFF;
  localparam int         FRAME_BITS = 32;

  localparam int ADC_TABLE_DEPTH = 6;
  localparam int TBL_AW          = $clog2(ADC_TABLE_DEPTH);

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } adc_reg_t;

  // Register writes in the order they go out after power-up.
  localparam adc_reg_t ADC_INIT_TABLE [ADC_TABLE_DEPTH] = '{
    '{addr: 4'h1, data: 16'hB2FF},
    '{addr: 4'h2, data: 16'h007F},
    '{addr: 4'h3, data: 16'h807F},
    '{addr: 4'hA, data: 16'h007F},
    '{addr: 4'hB, data: 16'h807F},
    '{addr: 4'hE, data: 16'h00FF}
  };

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } adc_state_e;

  // Frame word = {header, address, pad byte, data}, transmitted MSB first.
  function automatic logic [FRAME_BITS-1:0] adc_frame(input adc_reg_t r);
    return {FRAME_HDR, r.addr, FRAME_PAD, r.data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_sclk_gen
// Description : Half-period counter that produces the serial clock for the
//               ADC control port. While en_i is high, sclk toggles every HALF
//               clk cycles, starting low. While en_i is low, sclk is held low
//               and the counter is cleared.
// Ports       : clk    in   system clock
//               rst_n  in   asynchronous active-low reset
//               en_i   in   run enable
//               sclk_o out  registered serial clock
//               rise_o out  sclk goes 0->1 on the next clk edge
//               fall_o out  sclk goes 1->0 on the next clk edge
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sclk_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          w_wrap;

  assign w_wrap = en_i && (cnt_q == LAST);

  // Strobes announce the edge that the next clk will produce, so the
  // owner of sdata can update it in the same cycle sclk falls.
  assign rise_o = w_wrap && !sclk_q;
  assign fall_o = w_wrap &&  sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (w_wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule
`default_nettype wire

// File: rtl/adc_extended_control.sv
`default_nettype none
// ============================================================================
// Module      : adc_extended_control
// Description : Power-up configuration master for the ADC 3-wire extended
//               control port. After reset release it waits STARTUP_CYCLES,
//               then writes NUM_REGS table entries as 32-bit frames
//               (select low, MSB first, ADC samples sdata on sclk rise),
//               separated by GAP_CYCLES of select high, then idles with
//               done high until the next reset.
// Ports       : clk    in   system clock
//               rst_n  in   asynchronous active-low reset
//               sclk   out  serial clock, idle low
//               sdata  out  serial data, MSB first
//               select out  active-low frame select
//               done   out  all frames sent (sticky until reset)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_extended_control #(
  parameter int CLK_DIV        = 8,
  parameter int STARTUP_CYCLES = 1000,
  parameter int GAP_CYCLES     = 16,
  parameter int NUM_REGS       = 6
) (
  input  logic clk,
  input  logic rst_n,
  output logic sclk,
  output logic sdata,
  output logic select,
  output logic done
);

  import adc_ctrl_pkg::*;

  localparam int HALF   = CLK_DIV / 2;
  localparam int WAIT_W = $clog2(STARTUP_CYCLES + 2);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = TBL_AW + 1;
  localparam int BITS_W = $clog2(FRAME_BITS + 1);

  adc_state_e            state_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BITS_W-1:0]     bits_left_q;   // sclk rises still to come in this frame
  logic [FRAME_BITS-2:0] shreg_q;       // bits following the one on sdata
  logic                  sdata_q;
  logic                  select_q;
  logic                  done_q;

  logic                  w_sclk;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_gen_en;
  logic                  w_frame_end;
  logic                  w_launch;
  logic                  w_more;
  logic [FRAME_BITS-1:0] w_frame;

  // The generator already runs during LOAD so that the first rise comes
  // exactly half an sclk period after select falls.
  assign w_frame_end = (state_q == SHIFT) && (bits_left_q == '0) && !w_sclk;
  assign w_gen_en    = (state_q == LOAD) || ((state_q == SHIFT) && !w_frame_end);

  // A new frame (or the terminal state) is entered from WAIT after the
  // startup delay and from GAP after the inter-frame gap.
  assign w_launch = ((state_q == WAIT) && (wait_cnt_q == WAIT_W'(STARTUP_CYCLES))) ||
                    ((state_q == GAP)  && (gap_cnt_q  == GAP_W'(GAP_CYCLES - 1)));
  assign w_more   = (idx_q < IDX_W'(NUM_REGS));
  assign w_frame  = adc_frame(ADC_INIT_TABLE[idx_q[TBL_AW-1:0]]);

  adc_sclk_gen #(
    .HALF (HALF)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (w_gen_en),
    .sclk_o (w_sclk),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      bits_left_q <= '0;
      shreg_q     <= '0;
      sdata_q     <= 1'b0;
      select_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        WAIT:  wait_cnt_q <= wait_cnt_q + 1'b1;
        LOAD:  state_q    <= SHIFT;
        SHIFT: begin
          // Data moves on the falling edge, leaving a full high and low
          // half-period of setup/hold around every rising edge.
          if (w_fall && (bits_left_q != '0)) begin
            sdata_q <= shreg_q[FRAME_BITS-2];
            shreg_q <= {shreg_q[FRAME_BITS-3:0], 1'b0};
          end
          // One clk after the last fall: release select with sclk low.
          if (w_frame_end) begin
            select_q  <= 1'b1;
            sdata_q   <= 1'b0;
            idx_q     <= idx_q + 1'b1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end
        GAP:     gap_cnt_q <= gap_cnt_q + 1'b1;
        DONE:    state_q   <= DONE;
        default: state_q   <= WAIT;
      endcase

      // Rises happen only in LOAD/SHIFT, never in the same cycle as a launch.
      if (w_rise) begin
        bits_left_q <= bits_left_q - 1'b1;
      end

      if (w_launch) begin
        if (w_more) begin
          state_q     <= LOAD;
          shreg_q     <= w_frame[FRAME_BITS-2:0];
          sdata_q     <= w_frame[FRAME_BITS-1];
          select_q    <= 1'b0;
          bits_left_q <= BITS_W'(FRAME_BITS);
        end else begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign sclk   = w_sclk;
  assign sdata  = sdata_q;
  assign select = select_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_extended_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_extended_control
// Description : Self-checking bench for adc_extended_control. A bus monitor
//               acts as the ADC (samples sdata on sclk rise) and checks the
//               waveform timing; the main sequence checks reset values,
//               captured words, done timing, mid-frame aborts (fixed and
//               random points) and a NUM_REGS=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_extended_control;

  localparam int CLK_DIV = 8;
  localparam int STARTUP = 1000;
  localparam int GAP     = 16;
  localparam int NREGS   = 6;
  localparam int HALF    = CLK_DIV / 2;
  localparam int FRAME_LOW = 32 * CLK_DIV + 1;
  localparam int DONE_AT = STARTUP + 1 + NREGS * (FRAME_LOW + GAP);

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, sdata, select, done;
  logic sclk0, sdata0, sel0, done0;

  always #5 clk = ~clk;

  adc_extended_control #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP),
    .GAP_CYCLES     (GAP),
    .NUM_REGS       (NREGS)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .sdata  (sdata),
    .select (select),
    .done   (done)
  );

  adc_extended_control #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP),
    .GAP_CYCLES     (GAP),
    .NUM_REGS       (0)
  ) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk0),
    .sdata  (sdata0),
    .select (sel0),
    .done   (done0)
  );

  // Reference table, independent of the design package.
  logic [3:0]  m_addr [NREGS] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hE};
  logic [15:0] m_data [NREGS] = '{16'hB2FF, 16'h007F, 16'h807F, 16'h007F, 16'h807F, 16'h00FF};

  function automatic logic [31:0] exp_word(input int i);
    return {4'b0001, m_addr[i], 8'hFF, m_data[i]};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- ADC-side monitor ----------------
  int          cyc, n_fall, rises;
  int          t_sel_fall, t_sel_rise, t_last_rise, t_last_fall, t_sd_chg;
  logic        prev_sel, prev_sclk, prev_sd;
  logic [31:0] word;
  logic [31:0] cap_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; n_fall = 0; rises = 0; word = '0;
        t_sel_fall = -1000; t_sel_rise = 0; t_last_rise = -1000;
        t_last_fall = -1000; t_sd_chg = -1000;
        prev_sel = 1'b1; prev_sclk = 1'b0; prev_sd = 1'b0;
      end else begin
        cyc++;
        check("n0_idle", {61'd0, sel0, sclk0, sdata0}, 64'b100);
        if (select) check("sclk_idle", sclk, 0);

        if (sdata !== prev_sd) begin
          check("sdata_hold", (cyc - t_last_rise >= 2), 1);
          t_sd_chg = cyc;
        end

        if (!select && prev_sel) begin
          if (n_fall == 0) check("startup", cyc, STARTUP + 1);
          else             check("gap_min", (cyc - t_sel_rise >= GAP), 1);
          n_fall++;
          t_sel_fall = cyc;
          rises = 0;
          word = '0;
        end

        if (sclk && !prev_sclk) begin
          if (rises == 0) check("lead", cyc - t_sel_fall, HALF);
          else            check("sclk_low", cyc - t_last_fall, HALF);
          check("sdata_setup", (cyc - t_sd_chg >= 2), 1);
          word = {word[30:0], prev_sd};
          rises++;
          t_last_rise = cyc;
        end

        if (!sclk && prev_sclk) begin
          check("sclk_high", cyc - t_last_rise, HALF);
          t_last_fall = cyc;
        end

        if (select && !prev_sel) begin
          check("frame_len", cyc - t_sel_fall, FRAME_LOW);
          check("rise_cnt", rises, 32);
          cap_q.push_back(word);
          t_sel_rise = cyc;
        end

        prev_sel = select; prev_sclk = sclk; prev_sd = sdata;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic check_words(input string tag);
    check({tag, "_nwords"}, cap_q.size(), NREGS);
    for (int i = 0; i < NREGS; i++) begin
      check($sformatf("%s_word%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 32'h0, exp_word(i));
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 1; i <= DONE_AT + 200 && at < 0; i++) begin
      @(negedge clk); #1;
      if (done) at = i;
    end
  endtask

  task automatic wait_point(input int f, input int b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_fall == f && rises == b) ok = 1'b1;
    end
    check($sformatf("reach_f%0d_b%0d", f, b), ok, 1);
  endtask

  // Assert reset between clock edges and check outputs drop at once.
  task automatic abort_and_restart(input string tag, input int hold);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_sel"}, select, 1);
    check({tag, "_sclk"}, sclk, 0);
    repeat (hold) @(negedge clk);
    cap_q.delete();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int at, at0, nb, f, b;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("rst_select", select, 1);
    check("rst_sclk", sclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_done", done, 0);
    check("rst_done0", done0, 0);
    cap_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full power-up sequence, with the NUM_REGS=0 instance alongside.
    at = -1; at0 = -1;
    for (int i = 1; i <= DONE_AT + 200 && at < 0; i++) begin
      @(negedge clk); #1;
      if (done0 && at0 < 0) at0 = i;
      if (done && at < 0) at = i;
    end
    check("n0_done_at", at0, STARTUP + 1);
    check("done_at", at, DONE_AT);
    check_words("run1");

    // Nothing more happens once done.
    nb = n_fall;
    repeat (10000) @(negedge clk);
    #1;
    check("quiet_frames", n_fall - nb, 0);
    check("done_hold", done, 1);

    // Fresh reset, then abort during bit 12 of frame 3.
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    cap_q.delete();
    #2 rst_n = 1'b1;
    wait_point(3, 12);
    abort_and_restart("abort_f3", 10);
    check("abort_done", done, 0);
    for (int i = 0; i < STARTUP + 600 && cap_q.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    check("restart_word0", (cap_q.size() > 0) ? cap_q[0] : 32'h0, exp_word(0));

    // Abort at a random frame/bit, then run to completion.
    f = int'($urandom_range(2, NREGS));
    b = int'($urandom_range(1, 31));
    wait_point(f, b);
    abort_and_restart("abort_rnd", int'($urandom_range(1, 20)));
    wait_done(at);
    check("done_at_rnd", at, DONE_AT);
    check_words("run2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
